// File: rtl/snake_move_ctrl.sv
// Game-flow and motion controller for the snake: start/run/pause/dead sequencing,
// step timing with speed levels, and reversal-safe direction commit.
module snake_move_ctrl #(
  parameter int unsigned STEP_CYCLES = 12_500_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_start,
  input  logic       pause,
  input  logic       collide,
  input  logic       ate_food,
  output logic [1:0] dir,
  output logic       step,
  output logic       game_reset,
  output logic [1:0] state,
  output logic [1:0] speed_lvl
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDead  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] StepCyc = CNT_W'(STEP_CYCLES);

  state_e           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       speed_q, speed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             game_reset_q, game_reset_d;

  logic [CNT_W-1:0] thresh;
  logic             terminal;
  logic             btn_any;
  logic [1:0]       btn_code;

  // >= rather than == so a speed-up mid-period fires at once instead of wrapping.
  always_comb begin
    thresh   = (StepCyc >> speed_q) - CNT_W'(1);
    terminal = (cnt_q >= thresh);
  end

  always_comb begin
    btn_any  = btn_up | btn_right | btn_down | btn_left;
    btn_code = 2'b11;
    if (btn_up)         btn_code = 2'b00;
    else if (btn_right) btn_code = 2'b01;
    else if (btn_down)  btn_code = 2'b10;
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    pend_d       = pend_q;
    speed_d      = speed_q;
    cnt_d        = cnt_q;
    step_d       = 1'b0;
    game_reset_d = 1'b0;

    unique case (state_q)
      StIdle, StDead: begin
        if (btn_start) begin
          state_d      = StRun;
          game_reset_d = 1'b1;
          cnt_d        = '0;
          speed_d      = 2'd0;
          dir_d        = 2'b01;
          pend_d       = 2'b01;
        end
      end
      StRun: begin
        if (collide) begin
          state_d = StDead;
          cnt_d   = '0;
        end else if (pause) begin
          state_d = StPause;
        end else begin
          // Reversal is judged against the committed direction only.
          if (btn_any && ((dir_q ^ btn_code) != 2'b10)) pend_d = btn_code;
          if (ate_food && (speed_q != 2'd3)) speed_d = speed_q + 2'd1;
          if (terminal) begin
            step_d = 1'b1;
            cnt_d  = '0;
            dir_d  = pend_d;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StPause: begin
        // The release cycle counts, so the step slips by exactly the pause length.
        if (!pause) begin
          state_d = StRun;
          if (terminal) begin
            step_d = 1'b1;
            cnt_d  = '0;
            dir_d  = pend_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      dir_q        <= 2'b01;
      pend_q       <= 2'b01;
      speed_q      <= 2'd0;
      cnt_q        <= '0;
      step_q       <= 1'b0;
      game_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      speed_q      <= speed_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      game_reset_q <= game_reset_d;
    end
  end

  assign dir        = dir_q;
  assign step       = step_q;
  assign game_reset = game_reset_q;
  assign state      = state_q;
  assign speed_lvl  = speed_q;

endmodule
